ps2_rx_ctrl: RTL and testbench

PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_rx_ctrl_if.sv | 29 ++
 rtl/ps2_sc_fifo.sv | 61 ++++++
 rtl/ps2_rx_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ps2_rx_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive controller.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS  = 11;
    localparam int unsigned PS2_DATA_BITS   = 8;
    localparam int unsigned DEF_FIFO_DEPTH  = 8;
    localparam int unsigned DEF_FILTER_LEN  = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 100000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // True when data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// PS/2 line inputs plus register-file side read/status signals.
interface ps2_rx_ctrl_if import ps2_pkg::*; #(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             ps2_clk;
    logic             ps2_data;
    logic             rd_pop;
    logic             err_clr;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             err_parity;
    logic             err_frame;
    logic             err_overflow;
    logic             irq;

    modport master (
        output ps2_clk, ps2_data, rd_pop, err_clr,
        input  rd_data, rd_valid, fifo_count, err_parity, err_frame, err_overflow, irq
    );

    modport slave (
        input  ps2_clk, ps2_data, rd_pop, err_clr,
        output rd_data, rd_valid, fifo_count, err_parity, err_frame, err_overflow, irq
    );

endinterface

// File: rtl/ps2_sc_fifo.sv
// Scan-code FIFO; head holds the last popped byte while empty.
module ps2_sc_fifo import ps2_pkg::*; #(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = PS2_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [WIDTH-1:0]             head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic             do_pop;
    logic             do_push;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign count   = cnt;
    assign head    = empty ? hold : mem[rd_ptr];

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold   <= mem[rd_ptr];
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver with glitch filter, frame checks and scan-code FIFO.
module ps2_rx_ctrl import ps2_pkg::*; #(
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          ACLK,
    input  logic          ARESET,
    ps2_rx_ctrl_if.slave  bus
);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BC_W  = $clog2(PS2_DATA_BITS);

    logic [1:0]               clk_s;
    logic [1:0]               dat_s;
    logic                     filt_clk;
    logic                     filt_prev;
    logic [FLT_W-1:0]         flt_cnt;
    logic                     fall_c;
    logic                     dat;

    ps2_state_e               state;
    logic [PS2_DATA_BITS-1:0] shift;
    logic [BC_W-1:0]          bit_cnt;
    logic                     par_bit;
    logic [TO_W-1:0]          to_cnt;
    logic                     push_q;
    logic [PS2_DATA_BITS-1:0] push_data_q;
    logic                     par_evt_q;
    logic                     frm_evt_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_cnt;
    logic [PS2_DATA_BITS-1:0] fifo_head;
    logic                     ovf_c;

    logic                     err_parity_q;
    logic                     err_frame_q;
    logic                     err_overflow_q;

    // Two-flop synchronizers for both PS/2 lines; idle bus level is 1.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
        end else begin
            clk_s <= {clk_s[0], bus.ps2_clk};
            dat_s <= {dat_s[0], bus.ps2_data};
        end
    end

    // Filtered clock follows the synchronized clock only after FILTER_LEN equal samples.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s[1] != filt_clk) begin
                if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s[1];
                    flt_cnt  <= '0;
                end else begin
                    flt_cnt <= flt_cnt + FLT_W'(1);
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fall_c = filt_prev & ~filt_clk;
    assign dat    = dat_s[1];

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; with inter-edge timeout.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= ST_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            par_evt_q   <= 1'b0;
            frm_evt_q   <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            par_evt_q <= 1'b0;
            frm_evt_q <= 1'b0;

            if (state == ST_IDLE || fall_c) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    if (fall_c && !dat) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall_c) begin
                        shift   <= {dat, shift[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BC_W'(1);
                        if (bit_cnt == BC_W'(PS2_DATA_BITS - 1)) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fall_c) begin
                        par_bit <= dat;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall_c) begin
                        state <= ST_IDLE;
                        if (!dat) begin
                            frm_evt_q <= 1'b1;
                        end else if (!odd_parity_ok(shift, par_bit)) begin
                            par_evt_q <= 1'b1;
                        end else begin
                            push_q      <= 1'b1;
                            push_data_q <= shift;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Stalled frame: drop the partial byte and report a framing error.
            if (state != ST_IDLE && !fall_c && to_cnt == TO_W'(TIMEOUT_CYC)) begin
                state     <= ST_IDLE;
                shift     <= '0;
                bit_cnt   <= '0;
                to_cnt    <= '0;
                frm_evt_q <= 1'b1;
            end
        end
    end

    ps2_sc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_DATA_BITS)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (bus.rd_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt),
        .head      (fifo_head)
    );

    assign ovf_c = push_q & fifo_full & ~bus.rd_pop;

    // Sticky error flags; a new event outranks a same-cycle clear.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_parity_q   <= 1'b0;
            err_frame_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            err_parity_q   <= (err_parity_q   & ~bus.err_clr) | par_evt_q;
            err_frame_q    <= (err_frame_q    & ~bus.err_clr) | frm_evt_q;
            err_overflow_q <= (err_overflow_q & ~bus.err_clr) | ovf_c;
        end
    end

    assign bus.rd_data      = fifo_head;
    assign bus.rd_valid     = ~fifo_empty;
    assign bus.fifo_count   = fifo_cnt;
    assign bus.err_parity   = err_parity_q;
    assign bus.err_frame    = err_frame_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.irq          = ~fifo_empty | err_parity_q | err_frame_q | err_overflow_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Scoreboard bench for ps2_rx_ctrl: PS/2 frames in, popped bytes and flags checked against a queue model.
module tb_ps2_rx_ctrl;
    import ps2_pkg::*;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned HALF_PER = 20;

    logic ACLK;
    logic areset;

    ps2_rx_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .FILTER_LEN  (2),
        .TIMEOUT_CYC (200)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (areset),
        .bus    (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_rd = 8'h00;
    logic       e_par = 1'b0;
    logic       e_frm = 1'b0;
    logic       e_ovf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must return the oldest expected byte.
    always @(negedge ACLK) begin
        if (!areset && bus.rd_pop) begin
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_extra: got=%0h want=none at %0t", bus.rd_data, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("pop_data", 32'(bus.rd_data), 32'(e));
                    last_rd = e;
                end
            end else if (exp_q.size() != 0) begin
                chk("pop_valid", 32'(bus.rd_valid), 32'd1);
            end
        end
    end

    task automatic chk_state(input string nm);
        logic [7:0] exp_rd;
        @(negedge ACLK);
        exp_rd = (exp_q.size() != 0) ? exp_q[0] : last_rd;
        chk({nm, ":rd_valid"},  32'(bus.rd_valid),     32'(exp_q.size() != 0));
        chk({nm, ":count"},     32'(bus.fifo_count),   32'(exp_q.size()));
        chk({nm, ":rd_data"},   32'(bus.rd_data),      32'(exp_rd));
        chk({nm, ":err_par"},   32'(bus.err_parity),   32'(e_par));
        chk({nm, ":err_frm"},   32'(bus.err_frame),    32'(e_frm));
        chk({nm, ":err_ovf"},   32'(bus.err_overflow), 32'(e_ovf));
        chk({nm, ":irq"},       32'(bus.irq),
            32'((exp_q.size() != 0) | e_par | e_frm | e_ovf));
    endtask

    // One PS/2 bit: data set while clock high, then a low phase. Optionally
    // pulse rd_pop in the cycle the receiver pushes after a stop-bit edge
    // (2 sync + 2 filter + 1 edge-detect cycles after the line falls).
    task automatic ps2_bit(input logic d, input bit pop_at_push);
        @(posedge ACLK); #1;
        bus.ps2_data = d;
        repeat (HALF_PER - 1) @(posedge ACLK);
        #1;
        bus.ps2_clk = 1'b0;
        if (pop_at_push) begin
            repeat (5) @(posedge ACLK);
            #1 bus.rd_pop = 1'b1;
            @(posedge ACLK);
            #1 bus.rd_pop = 1'b0;
            repeat (HALF_PER - 6) @(posedge ACLK);
        end else begin
            repeat (HALF_PER) @(posedge ACLK);
        end
        #1 bus.ps2_clk = 1'b1;
    endtask

    // mode 0 = good frame, 1 = wrong parity, 2 = stop bit 0.
    task automatic send_frame(input logic [7:0] b, input int mode, input bit pop_at_push);
        logic p;
        logic stop;
        p    = ~(^b);
        if (mode == 1) p = ~p;
        stop = (mode == 2) ? 1'b0 : 1'b1;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(p, 1'b0);
        ps2_bit(stop, pop_at_push);
        bus.ps2_data = 1'b1;
        repeat (10) @(posedge ACLK);
        case (mode)
            0: begin
                if (exp_q.size() < DEPTH) exp_q.push_back(b);
                else e_ovf = 1'b1;
            end
            1: e_par = 1'b1;
            default: e_frm = 1'b1;
        endcase
    endtask

    task automatic pop_once();
        @(posedge ACLK); #1 bus.rd_pop = 1'b1;
        @(posedge ACLK); #1 bus.rd_pop = 1'b0;
    endtask

    task automatic clear_errs();
        @(posedge ACLK); #1 bus.err_clr = 1'b1;
        @(posedge ACLK); #1 bus.err_clr = 1'b0;
        e_par = 1'b0;
        e_frm = 1'b0;
        e_ovf = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        int         md;
        areset       = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.rd_pop   = 1'b0;
        bus.err_clr  = 1'b0;
        repeat (5) @(posedge ACLK);
        chk_state("reset");
        @(posedge ACLK); #1 areset = 1'b0;
        repeat (5) @(posedge ACLK);

        // Single good byte then pop.
        send_frame(8'h1C, 0, 1'b0);
        chk_state("rx_1c");
        pop_once();
        chk_state("rx_1c_pop");

        // Parity error and clear.
        send_frame(8'hF0, 1, 1'b0);
        chk_state("par_err");
        clear_errs();
        chk_state("par_clr");

        // Pop while empty is ignored and rd_data holds.
        pop_once();
        chk_state("pop_empty");

        // Overflow on the ninth byte.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0);
        chk_state("ovf");
        for (int i = 0; i < 8; i++) pop_once();
        chk_state("ovf_drain");
        clear_errs();

        // Full FIFO with pop coinciding with the push of 0xAA.
        for (int i = 0; i < 8; i++) send_frame(8'($urandom_range(0, 255)), 0, 1'b0);
        chk_state("full");
        send_frame(8'hAA, 0, 1'b1);
        chk_state("push_pop_full");
        for (int i = 0; i < 8; i++) pop_once();
        chk_state("push_pop_drain");
        chk("last_pop_aa", 32'(bus.rd_data), 32'h0000_00AA);

        // Stalled frame after 4 data bits.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        repeat (80) @(posedge ACLK);
        chk_state("to_early");
        repeat (200) @(posedge ACLK);
        e_frm = 1'b1;
        chk_state("timeout");
        clear_errs();
        send_frame(8'h5A, 0, 1'b0);
        chk_state("after_to");
        pop_once();

        // Randomized frames, errors and pops.
        for (int n = 0; n < 14; n++) begin
            rb = 8'($urandom_range(0, 255));
            md = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
            send_frame(rb, md, 1'b0);
            chk_state("rand");
            if ($urandom_range(0, 2) == 0) pop_once();
            if ($urandom_range(0, 3) == 0) begin
                clear_errs();
                chk_state("rand_clr");
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) pop_once();
        clear_errs();
        chk_state("rand_drain");

        // Reset in the middle of DATA with content and a flag present.
        send_frame(8'h33, 0, 1'b0);
        send_frame(8'h44, 2, 1'b0);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        @(posedge ACLK); #1 areset = 1'b1;
        @(posedge ACLK);
        exp_q.delete();
        last_rd = 8'h00;
        e_par = 1'b0;
        e_frm = 1'b0;
        e_ovf = 1'b0;
        chk_state("mid_reset");
        @(posedge ACLK); #1 areset = 1'b0;
        repeat (300) @(posedge ACLK);
        chk_state("post_reset_idle");
        send_frame(8'h1C, 0, 1'b0);
        chk_state("post_reset_rx");
        pop_once();
        chk_state("post_reset_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
